// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: register index/data widths, writeback entries and
// the write-scheduler state encoding.
package riscv_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    HOLD   = 1'b1
  } sched_state_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency results ({rd, data}) until the
// register-file write port is free.
module wb_result_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                din,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is still legal then.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register file's single write port between MEM/WB writeback and
// buffered long-latency results, and stalls decode on hazards against pending results.
module regfile_write_scheduler
  import riscv_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_reg_write,
  input  logic [REG_IDX_W-1:0] pipe_write_reg,
  input  logic [XLEN-1:0]      pipe_write_data,
  input  logic                 mc_issue,
  input  logic [REG_IDX_W-1:0] mc_issue_rd,
  input  logic                 mc_valid,
  input  logic [REG_IDX_W-1:0] mc_rd,
  input  logic [XLEN-1:0]      mc_data,
  output logic                 mc_ready,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  output logic                 dec_stall,
  output logic                 pipe_hold,
  output logic                 do_reg_write,
  output logic [REG_IDX_W-1:0] do_write_reg,
  output logic [XLEN-1:0]      write_data
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int PC_W = $clog2(MAX_PENDING + 1);

  sched_state_t             state, state_next;
  wb_entry_t                buf_head;
  logic                     buf_full, buf_empty;
  logic [$clog2(BUF_DEPTH):0] buf_count;
  logic                     pipe_wr, pop, starving;
  logic [SC_W-1:0]          starve_cnt;
  logic [31:0]              pending, pending_next;
  logic [PC_W-1:0]          pend_cnt;
  logic                     issue_acc, clr;
  logic [REG_IDX_W-1:0]     last_reg;
  logic [XLEN-1:0]          last_data;

  wb_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (mc_valid && mc_ready),
    .din   ('{rd: mc_rd, data: mc_data}),
    .pop   (pop),
    .head  (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign mc_ready = !buf_full;
  assign starving = (buf_count != '0) && !pop;

  always_comb begin
    state_next = state;
    pipe_hold  = 1'b0;
    pipe_wr    = 1'b0;
    pop        = 1'b0;
    case (state)
      NORMAL: begin
        pipe_wr = pipe_reg_write && (pipe_write_reg != REG_ZERO);
        pop     = !buf_empty && !pipe_wr;
        if (!buf_empty && !pipe_wr && 1'b0) state_next = NORMAL;
        if (starving && starve_cnt == SC_W'(STARVE_LIMIT - 1)) state_next = HOLD;
      end
      HOLD: begin
        pipe_hold  = 1'b1;
        pop        = !buf_empty;
        state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  // Index/data hold their last committed value when the port is idle.
  always_comb begin
    do_reg_write = 1'b0;
    do_write_reg = last_reg;
    write_data   = last_data;
    if (pipe_wr) begin
      do_reg_write = 1'b1;
      do_write_reg = pipe_write_reg;
      write_data   = pipe_write_data;
    end else if (pop && buf_head.rd != REG_ZERO) begin
      do_reg_write = 1'b1;
      do_write_reg = buf_head.rd;
      write_data   = buf_head.data;
    end
  end

  assign dec_stall = (pending[dec_rs1] && dec_rs1 != REG_ZERO)
                  || (pending[dec_rs2] && dec_rs2 != REG_ZERO)
                  || (mc_issue && pending[dec_rd] && dec_rd != REG_ZERO)
                  || (mc_issue && pend_cnt == PC_W'(MAX_PENDING))
                  || pipe_hold;

  assign issue_acc = mc_issue && !dec_stall && (mc_issue_rd != REG_ZERO);
  assign clr       = pop && (buf_head.rd != REG_ZERO) && pending[buf_head.rd];

  always_comb begin
    pending_next = pending;
    if (clr) pending_next[buf_head.rd] = 1'b0;
    if (issue_acc) pending_next[mc_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      pending    <= '0;
      pend_cnt   <= '0;
      last_reg   <= '0;
      last_data  <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (issue_acc && !clr && pend_cnt != PC_W'(MAX_PENDING)) begin
        pend_cnt <= pend_cnt + 1'b1;
      end else if (clr && !issue_acc) begin
        pend_cnt <= pend_cnt - 1'b1;
      end
      if (!starving || state_next == HOLD) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (do_reg_write) begin
        last_reg  <= do_write_reg;
        last_data <= write_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: pipe writes, long-latency drains,
// starvation hold, scoreboard limits, x0 results and mid-operation reset.
module tb_regfile_write_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_reg_write;
  logic [4:0]  pipe_write_reg;
  logic [31:0] pipe_write_data;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_stall, pipe_hold, do_reg_write;
  logic [4:0]  do_write_reg;
  logic [31:0] write_data;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_write_scheduler #(.BUF_DEPTH(2), .MAX_PENDING(4), .STARVE_LIMIT(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pipe_reg_write  (pipe_reg_write),
    .pipe_write_reg  (pipe_write_reg),
    .pipe_write_data (pipe_write_data),
    .mc_issue        (mc_issue),
    .mc_issue_rd     (mc_issue_rd),
    .mc_valid        (mc_valid),
    .mc_rd           (mc_rd),
    .mc_data         (mc_data),
    .mc_ready        (mc_ready),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_rd          (dec_rd),
    .dec_stall       (dec_stall),
    .pipe_hold       (pipe_hold),
    .do_reg_write    (do_reg_write),
    .do_write_reg    (do_write_reg),
    .write_data      (write_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic applyStimulus(input logic pw, input logic [4:0] pr, input logic [31:0] pd,
                               input logic iss, input logic [4:0] issrd,
                               input logic mv, input logic [4:0] mr, input logic [31:0] md,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    pipe_reg_write = pw;  pipe_write_reg = pr;  pipe_write_data = pd;
    mc_issue = iss;       mc_issue_rd = issrd;
    mc_valid = mv;        mc_rd = mr;           mc_data = md;
    dec_rs1 = rs1;        dec_rs2 = rs2;        dec_rd = rd;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic en, input logic [4:0] r, input logic [31:0] d);
    checkOutput({tag, "_we"}, 32'(do_reg_write), 32'(en));
    if (en) begin
      checkOutput({tag, "_reg"}, 32'(do_write_reg), 32'(r));
      checkOutput({tag, "_data"}, write_data, d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_mc_ready", 32'(mc_ready), 1);
    checkOutput("rst_dec_stall", 32'(dec_stall), 0);
    checkOutput("rst_pipe_hold", 32'(pipe_hold), 0);
    checkOutput("rst_we", 32'(do_reg_write), 0);
    checkOutput("rst_reg", 32'(do_write_reg), 0);
    checkOutput("rst_data", write_data, 0);
    step();
    rst_n = 1'b1;

    // Plain pipeline writeback goes straight through in the same cycle
    applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
    checkWrite("pipe_wr", 1, 5, 32'h1234);
    checkOutput("pipe_mc_ready", 32'(mc_ready), 1);
    checkOutput("pipe_stall", 32'(dec_stall), 0);
    step();

    // Long-latency op to x7 and its RAW stall window
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 7);
    checkOutput("iss7_stall", 32'(dec_stall), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'hDEAD, 7, 0, 0);
    checkOutput("x7_push_stall", 32'(dec_stall), 1);
    checkOutput("x7_push_we", 32'(do_reg_write), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    checkWrite("x7_drain", 1, 7, 32'hDEAD);
    checkOutput("x7_drain_stall", 32'(dec_stall), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    checkOutput("x7_after_stall", 32'(dec_stall), 0);
    checkOutput("x7_after_we", 32'(do_reg_write), 0);
    step();

    // Starvation: pipe writes x10 every cycle while two results wait
    applyStimulus(1, 10, 32'hA0, 1, 8, 0, 0, 0, 0, 0, 8);
    step();
    applyStimulus(1, 10, 32'hA1, 1, 9, 0, 0, 0, 0, 0, 9);
    step();
    applyStimulus(1, 10, 32'hA2, 0, 0, 1, 8, 32'h8888, 0, 0, 0);
    step();
    applyStimulus(1, 10, 32'hA3, 0, 0, 1, 9, 32'h9999, 0, 0, 0);
    checkOutput("st_ready_one", 32'(mc_ready), 1);
    step();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 10, 32'hB0 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("st_full_%0d", i), 32'(mc_ready), 0);
      checkOutput($sformatf("st_nohold_%0d", i), 32'(pipe_hold), 0);
      checkWrite($sformatf("st_pipe_%0d", i), 1, 10, 32'hB0 + 32'(i));
      step();
    end
    applyStimulus(1, 10, 32'hC0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_pipe_hold", 32'(pipe_hold), 1);
    checkOutput("hold_stall", 32'(dec_stall), 1);
    checkWrite("hold_head", 1, 8, 32'h8888);
    step();
    applyStimulus(1, 10, 32'hC1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_hold", 32'(pipe_hold), 0);
    checkOutput("post_stall", 32'(dec_stall), 0);
    checkWrite("post_pipe", 1, 10, 32'hC1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkWrite("drain_x9", 1, 9, 32'h9999);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 8, 0);
    checkOutput("x8x9_clear_stall", 32'(dec_stall), 0);
    checkOutput("x8x9_clear_ready", 32'(mc_ready), 1);
    step();

    // Scoreboard limit: four outstanding ops block a fifth
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(0, 0, 0, 1, 5'(r), 0, 0, 0, 0, 0, 5'(r));
      checkOutput($sformatf("iss_x%0d", r), 32'(dec_stall), 0);
      step();
    end
    applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 5);
    checkOutput("max_stall_a", 32'(dec_stall), 1);
    step();
    applyStimulus(0, 0, 0, 1, 5, 1, 2, 32'h2222, 0, 0, 5);
    checkOutput("max_stall_b", 32'(dec_stall), 1);
    step();
    applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 5);
    checkWrite("drain_x2", 1, 2, 32'h2222);
    checkOutput("max_stall_drain", 32'(dec_stall), 1);
    step();
    applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 5);
    checkOutput("fifth_accepted", 32'(dec_stall), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    checkOutput("x5_pending", 32'(dec_stall), 1);
    step();

    // Result for x0: popped silently, scoreboard untouched
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    checkOutput("x0_pop_we", 32'(do_reg_write), 0);
    checkOutput("x0_x3_still", 32'(dec_stall), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    checkOutput("x2_cleared", 32'(dec_stall), 0);
    checkOutput("x0_ready", 32'(mc_ready), 1);
    step();

    // Reset with two buffered results and several pending registers
    applyStimulus(1, 10, 32'hD0, 0, 0, 1, 1, 32'h1111, 0, 0, 0);
    step();
    applyStimulus(1, 10, 32'hD1, 0, 0, 1, 3, 32'h3333, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    checkOutput("pre_rst_full", 32'(mc_ready), 0);
    checkOutput("pre_rst_stall", 32'(dec_stall), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_we", 32'(do_reg_write), 0);
    checkOutput("mid_rst_ready", 32'(mc_ready), 1);
    checkOutput("mid_rst_stall", 32'(dec_stall), 0);
    checkOutput("mid_rst_hold", 32'(pipe_hold), 0);
    checkOutput("mid_rst_reg", 32'(do_write_reg), 0);
    checkOutput("mid_rst_data", write_data, 0);
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    checkOutput("post_rst_we", 32'(do_reg_write), 0);
    checkOutput("post_rst_stall", 32'(dec_stall), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 0);
    checkOutput("post_rst_we2", 32'(do_reg_write), 0);
    checkOutput("post_rst_stall2", 32'(dec_stall), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
